ex_stage_pipe: RTL

EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

---
 rtl/ex_stage_pipe.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - execute stage: ALU, branch compare, redirect with shadow discard,
// registered write-back and load/store queue writes.
module ex_stage_pipe #(
  parameter int C_XLEN   = 32,
  parameter int C_PC_INC = 4,
  parameter int C_SHADOW = 2
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              ids_dav_i,
  output logic              ids_ack_o,
  input  logic [1:0]        ids_zone_i,
  input  logic              ids_cond_i,
  input  logic              ids_jump_i,
  input  logic              ids_link_i,
  input  logic [C_XLEN-1:0] ids_pc_i,
  input  logic [C_XLEN-1:0] ids_operand_left_i,
  input  logic [C_XLEN-1:0] ids_operand_right_i,
  input  logic [C_XLEN-1:0] ids_regs1_data_i,
  input  logic [C_XLEN-1:0] ids_regs2_data_i,
  input  logic [3:0]        ids_alu_op_i,
  input  logic [4:0]        ids_regd_addr_i,
  input  logic [2:0]        ids_funct3_i,
  input  logic              lsq_lq_full_i,
  input  logic              lsq_sq_full_i,
  output logic              ids_regd_wr_o,
  output logic [4:0]        ids_regd_addr_o,
  output logic [C_XLEN-1:0] ids_regd_data_o,
  output logic              hvec_vec_strobe_o,
  output logic [C_XLEN-1:0] hvec_vec_o,
  output logic [C_XLEN-1:0] hvec_pc_o,
  output logic              lsq_lq_wr_o,
  output logic              lsq_sq_wr_o,
  output logic [2:0]        lsq_funct3_o,
  output logic [4:0]        lsq_regd_addr_o,
  output logic [C_XLEN-1:0] lsq_regs2_data_o,
  output logic [C_XLEN-1:0] lsq_addr_o
);

  localparam int SHW = (C_XLEN == 64) ? 6 : 5;
  localparam logic [1:0] ZONE_REGFILE = 2'd1;
  localparam logic [1:0] ZONE_LOADQ   = 2'd2;
  localparam logic [1:0] ZONE_STOREQ  = 2'd3;

  logic [C_XLEN-1:0] alu_res;
  logic [SHW-1:0]    shamt;
  logic              cmp_true;
  logic              in_shadow, lsq_block, xfer, exec, redirect;

  logic [2:0]        shadow_q, shadow_d;
  logic              regd_wr_q, regd_wr_d;
  logic [4:0]        regd_addr_q, regd_addr_d;
  logic [C_XLEN-1:0] regd_data_q, regd_data_d;
  logic              vec_strobe_q, vec_strobe_d;
  logic [C_XLEN-1:0] vec_q, vec_d;
  logic [C_XLEN-1:0] vec_pc_q, vec_pc_d;
  logic              lq_wr_q, lq_wr_d;
  logic              sq_wr_q, sq_wr_d;
  logic [2:0]        lsq_funct3_q, lsq_funct3_d;
  logic [4:0]        lsq_regd_addr_q, lsq_regd_addr_d;
  logic [C_XLEN-1:0] lsq_regs2_q, lsq_regs2_d;
  logic [C_XLEN-1:0] lsq_addr_q, lsq_addr_d;

  assign shamt = ids_operand_right_i[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ids_alu_op_i)
      4'd0: alu_res = ids_operand_left_i + ids_operand_right_i;
      4'd1: alu_res = ids_operand_left_i - ids_operand_right_i;
      4'd2: alu_res = ids_operand_left_i & ids_operand_right_i;
      4'd3: alu_res = ids_operand_left_i | ids_operand_right_i;
      4'd4: alu_res = ids_operand_left_i ^ ids_operand_right_i;
      4'd5: alu_res = {{(C_XLEN-1){1'b0}},
                       ($signed(ids_operand_left_i) < $signed(ids_operand_right_i))};
      4'd6: alu_res = {{(C_XLEN-1){1'b0}}, (ids_operand_left_i < ids_operand_right_i)};
      4'd7: alu_res = ids_operand_left_i << shamt;
      4'd8: alu_res = ids_operand_left_i >> shamt;
      4'd9: alu_res = $unsigned($signed(ids_operand_left_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cmp_true = 1'b0;
    case (ids_funct3_i)
      3'b000: cmp_true = (ids_regs1_data_i == ids_regs2_data_i);
      3'b001: cmp_true = (ids_regs1_data_i != ids_regs2_data_i);
      3'b100: cmp_true = ($signed(ids_regs1_data_i) <  $signed(ids_regs2_data_i));
      3'b101: cmp_true = ($signed(ids_regs1_data_i) >= $signed(ids_regs2_data_i));
      3'b110: cmp_true = (ids_regs1_data_i <  ids_regs2_data_i);
      3'b111: cmp_true = (ids_regs1_data_i >= ids_regs2_data_i);
      default: cmp_true = 1'b0;
    endcase
  end

  // Shadow instructions are discarded, so a full queue must not stall them.
  assign in_shadow = (shadow_q != 3'd0);
  assign lsq_block = ~in_shadow & (((ids_zone_i == ZONE_LOADQ) & lsq_lq_full_i) |
                                   ((ids_zone_i == ZONE_STOREQ) & lsq_sq_full_i));
  assign ids_ack_o = clk_en_i & ~lsq_block;
  assign xfer      = ids_dav_i & ids_ack_o;
  assign exec      = xfer & ~in_shadow;
  assign redirect  = ids_jump_i | (ids_cond_i & cmp_true);

  always_comb begin
    shadow_d        = shadow_q;
    regd_wr_d       = regd_wr_q;
    regd_addr_d     = regd_addr_q;
    regd_data_d     = regd_data_q;
    vec_strobe_d    = vec_strobe_q;
    vec_d           = vec_q;
    vec_pc_d        = vec_pc_q;
    lq_wr_d         = lq_wr_q;
    sq_wr_d         = sq_wr_q;
    lsq_funct3_d    = lsq_funct3_q;
    lsq_regd_addr_d = lsq_regd_addr_q;
    lsq_regs2_d     = lsq_regs2_q;
    lsq_addr_d      = lsq_addr_q;
    if (clk_en_i) begin
      regd_wr_d    = 1'b0;
      vec_strobe_d = 1'b0;
      lq_wr_d      = 1'b0;
      sq_wr_d      = 1'b0;
      if (xfer && in_shadow) begin
        shadow_d = shadow_q - 3'd1;
      end
      if (exec) begin
        regd_wr_d   = (ids_zone_i == ZONE_REGFILE) && (ids_regd_addr_i != 5'd0);
        regd_addr_d = ids_regd_addr_i;
        regd_data_d = ids_link_i ? (ids_pc_i + C_XLEN'(C_PC_INC)) : alu_res;
        if (redirect) begin
          shadow_d     = 3'(C_SHADOW);
          vec_strobe_d = 1'b1;
          vec_d        = {alu_res[C_XLEN-1:1], 1'b0};
          vec_pc_d     = ids_pc_i;
        end
        if ((ids_zone_i == ZONE_LOADQ) || (ids_zone_i == ZONE_STOREQ)) begin
          lq_wr_d         = (ids_zone_i == ZONE_LOADQ);
          sq_wr_d         = (ids_zone_i == ZONE_STOREQ);
          lsq_funct3_d    = ids_funct3_i;
          lsq_regd_addr_d = ids_regd_addr_i;
          lsq_regs2_d     = ids_regs2_data_i;
          lsq_addr_d      = alu_res;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      shadow_q        <= '0;
      regd_wr_q       <= 1'b0;
      regd_addr_q     <= '0;
      regd_data_q     <= '0;
      vec_strobe_q    <= 1'b0;
      vec_q           <= '0;
      vec_pc_q        <= '0;
      lq_wr_q         <= 1'b0;
      sq_wr_q         <= 1'b0;
      lsq_funct3_q    <= '0;
      lsq_regd_addr_q <= '0;
      lsq_regs2_q     <= '0;
      lsq_addr_q      <= '0;
    end else begin
      shadow_q        <= shadow_d;
      regd_wr_q       <= regd_wr_d;
      regd_addr_q     <= regd_addr_d;
      regd_data_q     <= regd_data_d;
      vec_strobe_q    <= vec_strobe_d;
      vec_q           <= vec_d;
      vec_pc_q        <= vec_pc_d;
      lq_wr_q         <= lq_wr_d;
      sq_wr_q         <= sq_wr_d;
      lsq_funct3_q    <= lsq_funct3_d;
      lsq_regd_addr_q <= lsq_regd_addr_d;
      lsq_regs2_q     <= lsq_regs2_d;
      lsq_addr_q      <= lsq_addr_d;
    end
  end

  assign ids_regd_wr_o     = regd_wr_q;
  assign ids_regd_addr_o   = regd_addr_q;
  assign ids_regd_data_o   = regd_data_q;
  assign hvec_vec_strobe_o = vec_strobe_q;
  assign hvec_vec_o        = vec_q;
  assign hvec_pc_o         = vec_pc_q;
  assign lsq_lq_wr_o       = lq_wr_q;
  assign lsq_sq_wr_o       = sq_wr_q;
  assign lsq_funct3_o      = lsq_funct3_q;
  assign lsq_regd_addr_o   = lsq_regd_addr_q;
  assign lsq_regs2_data_o  = lsq_regs2_q;
  assign lsq_addr_o        = lsq_addr_q;

endmodule
